// File: rtl/vme_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : vme_cmd_sequencer
//  Description : Replays a loaded list of VME read/write commands onto the
//                internal command/data register interface. Each read can be
//                compared against an expected value (saturating error count),
//                and every transaction is guarded by an acknowledge timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module vme_cmd_sequencer #(
    parameter int          DEPTH    = 16,
    parameter int          DATA_W   = 16,
    parameter logic [31:0] CMD_MASK = 32'h00a80000,
    parameter int          TIMEOUT  = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              load_en,
    input  logic              load_rw,
    input  logic [15:0]       load_instr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_chk,
    output logic              load_full,
    input  logic              run,
    input  logic              vme_cmd_rd,
    input  logic              vme_dat_wr,
    input  logic [31:0]       vme_dat_reg_out,
    output logic              start,
    output logic [31:0]       vme_cmd_reg,
    output logic [31:0]       vme_dat_reg_in,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [15:0]       rd_instr,
    output logic              busy,
    output logic              done,
    output logic [7:0]        err_cnt,
    output logic              timeout_err
);

    localparam int CW = $clog2(DEPTH + 1);   // entry count / replay index
    localparam int AW = $clog2(DEPTH);       // buffer address
    localparam int TW = $clog2(TIMEOUT + 1); // acknowledge timer

    localparam logic [31:0] C_RD_FLAG = 32'h0200_0000;
    localparam logic [31:0] C_WR_FLAG = 32'h0100_0000;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ISSUE    = 3'd1,
        ST_WAIT_ACK = 3'd2,
        ST_NEXT     = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Command buffer (contents need no reset; count defines validity)
    // ------------------------------------------------------------------
    logic              ent_rw_q    [DEPTH];
    logic [15:0]       ent_instr_q [DEPTH];
    logic [DATA_W-1:0] ent_data_q  [DEPTH];
    logic              ent_chk_q   [DEPTH];

    logic [CW-1:0]     count_q;
    logic              load_full_q;

    // ------------------------------------------------------------------
    // Sequencer state and registered outputs
    // ------------------------------------------------------------------
    state_t            state_q;
    logic [CW-1:0]     idx_q;
    logic [TW-1:0]     timer_q;
    logic              start_q;
    logic [31:0]       cmd_reg_q;
    logic [31:0]       dat_in_q;
    logic              rd_valid_q;
    logic [DATA_W-1:0] rd_data_q;
    logic [15:0]       rd_instr_q;
    logic              busy_q;
    logic              done_q;
    logic [7:0]        err_cnt_q;
    logic              timeout_err_q;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic              w_load_acc;
    logic              w_clr_acc;
    logic              w_ent_rw;
    logic [15:0]       w_ent_instr;
    logic [DATA_W-1:0] w_ent_data;
    logic              w_ent_chk;
    logic [CW-1:0]     w_idx_d;
    logic [CW-1:0]     w_count_d;
    logic [31:0]       w_cmd_word_d;
    logic [31:0]       w_wdata_d;
    logic [DATA_W-1:0] w_rdbk;
    logic              w_mismatch;
    logic [7:0]        w_err_cnt_d;
    logic              w_unused_rdbk;

    // Loads and clears are only honoured in IDLE, and run takes priority.
    assign w_load_acc = (state_q == ST_IDLE) && !run && load_en && !load_full_q;
    assign w_clr_acc  = (state_q == ST_IDLE) && !run && clr;
    assign w_count_d  = count_q + CW'(1);

    assign w_ent_rw    = ent_rw_q[idx_q[AW-1:0]];
    assign w_ent_instr = ent_instr_q[idx_q[AW-1:0]];
    assign w_ent_data  = ent_data_q[idx_q[AW-1:0]];
    assign w_ent_chk   = ent_chk_q[idx_q[AW-1:0]];

    assign w_idx_d      = idx_q + CW'(1);
    assign w_cmd_word_d = CMD_MASK | {16'h0000, w_ent_instr} |
                          (w_ent_rw ? C_RD_FLAG : C_WR_FLAG);

    assign w_rdbk        = vme_dat_reg_out[DATA_W-1:0];
    assign w_unused_rdbk = ^vme_dat_reg_out;
    assign w_mismatch    = w_ent_chk && (w_rdbk != w_ent_data);
    assign w_err_cnt_d   = (w_mismatch && (err_cnt_q != 8'hFF)) ?
                           (err_cnt_q + 8'd1) : err_cnt_q;

    // Zero-extend write data; reads put nothing on the data register.
    always_comb begin
        w_wdata_d = '0;
        if (!w_ent_rw) begin
            w_wdata_d[DATA_W-1:0] = w_ent_data;
        end
    end

    // Store an accepted load at the current fill position.
    always_ff @(posedge clk) begin
        if (w_load_acc) begin
            ent_rw_q[count_q[AW-1:0]]    <= load_rw;
            ent_instr_q[count_q[AW-1:0]] <= load_instr;
            ent_data_q[count_q[AW-1:0]]  <= load_data;
            ent_chk_q[count_q[AW-1:0]]   <= load_chk;
        end
    end

    // Track the number of loaded entries and the full flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q     <= '0;
            load_full_q <= 1'b0;
        end else if (w_clr_acc) begin
            count_q     <= '0;
            load_full_q <= 1'b0;
        end else if (w_load_acc) begin
            count_q     <= w_count_d;
            load_full_q <= (w_count_d == CW'(DEPTH));
        end
    end

    // Replay state machine with all interface outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            timer_q       <= '0;
            start_q       <= 1'b0;
            cmd_reg_q     <= CMD_MASK;
            dat_in_q      <= '0;
            rd_valid_q    <= 1'b0;
            rd_data_q     <= '0;
            rd_instr_q    <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_cnt_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            start_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (run) begin
                        err_cnt_q     <= '0;
                        timeout_err_q <= 1'b0;
                        idx_q         <= '0;
                        busy_q        <= 1'b1;
                        if (count_q == '0) begin
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            state_q <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (vme_cmd_rd) begin
                        start_q   <= 1'b1;
                        cmd_reg_q <= w_cmd_word_d;
                        dat_in_q  <= w_wdata_d;
                        timer_q   <= '0;
                        state_q   <= ST_WAIT_ACK;
                    end
                end
                ST_WAIT_ACK: begin
                    // An acknowledge on the final timer cycle still completes.
                    if (vme_dat_wr) begin
                        cmd_reg_q <= CMD_MASK;
                        dat_in_q  <= '0;
                        if (w_ent_rw) begin
                            rd_valid_q <= 1'b1;
                            rd_data_q  <= w_rdbk;
                            rd_instr_q <= w_ent_instr;
                            err_cnt_q  <= w_err_cnt_d;
                        end
                        state_q <= ST_NEXT;
                    end else if (timer_q == TW'(TIMEOUT)) begin
                        timeout_err_q <= 1'b1;
                        cmd_reg_q     <= CMD_MASK;
                        dat_in_q      <= '0;
                        done_q        <= 1'b1;
                        state_q       <= ST_DONE;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                ST_NEXT: begin
                    idx_q <= w_idx_d;
                    if (w_idx_d == count_q) begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        state_q <= ST_ISSUE;
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign load_full      = load_full_q;
    assign start          = start_q;
    assign vme_cmd_reg    = cmd_reg_q;
    assign vme_dat_reg_in = dat_in_q;
    assign rd_valid       = rd_valid_q;
    assign rd_data        = rd_data_q;
    assign rd_instr       = rd_instr_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err_cnt        = err_cnt_q;
    assign timeout_err    = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_vme_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vme_cmd_sequencer
//  Description : Randomised scoreboard bench for vme_cmd_sequencer with a
//                list-level reference model and a behavioural VME decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vme_cmd_sequencer;

    localparam int          DEPTH   = 4;
    localparam int          DATA_W  = 16;
    localparam int          TIMEOUT = 8;
    localparam logic [31:0] MASK    = 32'h00a80000;
    localparam int          NOACK   = TIMEOUT + 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              clr;
    logic              load_en;
    logic              load_rw;
    logic [15:0]       load_instr;
    logic [DATA_W-1:0] load_data;
    logic              load_chk;
    logic              load_full;
    logic              run;
    logic              vme_cmd_rd;
    logic              vme_dat_wr;
    logic [31:0]       vme_dat_reg_out;
    logic              start;
    logic [31:0]       vme_cmd_reg;
    logic [31:0]       vme_dat_reg_in;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic [15:0]       rd_instr;
    logic              busy;
    logic              done;
    logic [7:0]        err_cnt;
    logic              timeout_err;

    always #5 clk = ~clk;

    vme_cmd_sequencer #(
        .DEPTH(DEPTH), .DATA_W(DATA_W), .CMD_MASK(MASK), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .load_en(load_en), .load_rw(load_rw), .load_instr(load_instr),
        .load_data(load_data), .load_chk(load_chk), .load_full(load_full),
        .run(run), .vme_cmd_rd(vme_cmd_rd), .vme_dat_wr(vme_dat_wr),
        .vme_dat_reg_out(vme_dat_reg_out), .start(start),
        .vme_cmd_reg(vme_cmd_reg), .vme_dat_reg_in(vme_dat_reg_in),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_instr(rd_instr),
        .busy(busy), .done(done), .err_cnt(err_cnt), .timeout_err(timeout_err)
    );

    // ---------------- reference model state ----------------
    typedef struct { bit rw; bit [15:0] instr; bit [15:0] data; bit chk; } ent_t;
    typedef struct { bit [31:0] cmd; bit [31:0] dat; } cmd_exp_t;
    typedef struct { bit [15:0] data; bit [15:0] instr; int err; } rd_exp_t;
    typedef struct { int err; bit to; int n; int lat; } done_exp_t;

    ent_t      ref_list[$];
    cmd_exp_t  exp_cmd[$];
    rd_exp_t   exp_rd[$];
    done_exp_t exp_done[$];

    int        ack_dly [DEPTH];
    bit [31:0] rb_val  [DEPTH];
    bit        m_busy;
    bit        rdy_rand;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(string name, longint act, longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected replay of the current list under the chosen decoder behaviour.
    task automatic predict();
        int err = 0;
        int n = 0;
        bit to = 0;
        cmd_exp_t ce;
        rd_exp_t  re;
        done_exp_t de;
        for (int i = 0; i < ref_list.size(); i++) begin
            ce.cmd = MASK | {16'h0, ref_list[i].instr} |
                     (ref_list[i].rw ? 32'h0200_0000 : 32'h0100_0000);
            ce.dat = ref_list[i].rw ? 32'h0 : {16'h0, ref_list[i].data};
            exp_cmd.push_back(ce);
            n++;
            if (ack_dly[i] > TIMEOUT) begin
                to = 1;
                break;
            end
            if (ref_list[i].rw) begin
                re.data  = rb_val[i][15:0];
                re.instr = ref_list[i].instr;
                if (ref_list[i].chk && re.data != ref_list[i].data && err < 255) err++;
                re.err = err;
                exp_rd.push_back(re);
            end
        end
        de.err = err;
        de.to  = to;
        de.n   = n;
        de.lat = to ? TIMEOUT + 1 : -1;
        exp_done.push_back(de);
    endtask

    // ---------------- behavioural VME decoder ----------------
    int        tx_idx;
    int        ack_cnt = -1;
    bit [31:0] rb_cur;

    always @(negedge clk) begin
        vme_dat_wr      = 1'b0;
        vme_dat_reg_out = $urandom;
        if (rst) begin
            ack_cnt = -1;
        end else begin
            if (start && tx_idx < DEPTH) begin
                ack_cnt = (ack_dly[tx_idx] > TIMEOUT) ? -1 : ack_dly[tx_idx];
                rb_cur  = rb_val[tx_idx];
                tx_idx++;
            end
            if (ack_cnt == 0) begin
                vme_dat_wr      = 1'b1;
                vme_dat_reg_out = rb_cur;
                ack_cnt         = -1;
            end else if (ack_cnt > 0) begin
                ack_cnt--;
            end
        end
        vme_cmd_rd = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // ---------------- output monitor ----------------
    int        cyc = 0;
    int        mon_starts = 0;
    int        last_start = 0;
    cmd_exp_t  m_ce;
    rd_exp_t   m_re;
    done_exp_t m_de;

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (start) begin
                mon_starts++;
                last_start = cyc;
                if (exp_cmd.size() == 0) chk("unexpected_start", 1, 0);
                else begin
                    m_ce = exp_cmd.pop_front();
                    chk("cmd_word", vme_cmd_reg, m_ce.cmd);
                    chk("wr_data", vme_dat_reg_in, m_ce.dat);
                end
            end
            if (rd_valid) begin
                if (exp_rd.size() == 0) chk("unexpected_rd_valid", 1, 0);
                else begin
                    m_re = exp_rd.pop_front();
                    chk("rd_data", rd_data, m_re.data);
                    chk("rd_instr", rd_instr, m_re.instr);
                    chk("rd_err_cnt", err_cnt, m_re.err);
                end
            end
            if (done) begin
                if (exp_done.size() == 0) chk("unexpected_done", 1, 0);
                else begin
                    m_de = exp_done.pop_front();
                    chk("done_err_cnt", err_cnt, m_de.err);
                    chk("done_timeout_err", timeout_err, m_de.to);
                    chk("done_num_starts", mon_starts, m_de.n);
                    chk("done_cmd_idle", vme_cmd_reg, MASK);
                    chk("done_dat_idle", vme_dat_reg_in, 0);
                    if (m_de.lat >= 0) chk("timeout_latency", cyc - last_start, m_de.lat);
                end
                mon_starts = 0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic load(bit rw, bit [15:0] instr, bit [15:0] data, bit c);
        ent_t e;
        load_en = 1; load_rw = rw; load_instr = instr; load_data = data; load_chk = c;
        if (!m_busy && ref_list.size() < DEPTH) begin
            e.rw = rw; e.instr = instr; e.data = data; e.chk = c;
            ref_list.push_back(e);
        end
        @(negedge clk);
        load_en = 0;
        chk("load_full", load_full, ref_list.size() == DEPTH);
    endtask

    task automatic do_clr();
        clr = 1;
        @(negedge clk);
        clr = 0;
        ref_list.delete();
        chk("clr_load_full", load_full, 0);
    endtask

    task automatic do_run(bit poke, bit ld_same);
        int sz = ref_list.size();
        predict();
        tx_idx = 0;
        run = 1;
        if (ld_same) begin
            load_en = 1; load_rw = 0; load_instr = 16'hBEEF; load_data = 16'h5A5A; load_chk = 0;
        end
        @(negedge clk);
        run = 0; load_en = 0;
        m_busy = 1;
        chk("busy_after_run", busy, 1);
        chk("err_cnt_cleared", err_cnt, 0);
        chk("timeout_err_cleared", timeout_err, 0);
        if (sz == 0) chk("empty_done_pulse", done, 1);
        if (poke && sz > 0) begin
            load_en = 1; load_rw = 1; load_instr = 16'h7777; load_data = 16'h1111; load_chk = 1;
            @(negedge clk);
            load_en = 0;
            run = 1;
            @(negedge clk);
            run = 0;
        end
        for (int i = 0; i < 2000 && exp_done.size() != 0; i++) @(negedge clk);
        chk("replay_finished", exp_done.size(), 0);
        @(negedge clk);
        chk("busy_after_done", busy, 0);
        m_busy = 0;
        exp_cmd.delete(); exp_rd.delete(); exp_done.delete();
    endtask

    task automatic check_reset_vals(string tag);
        chk({tag, "_start"}, start, 0);
        chk({tag, "_cmd_reg"}, vme_cmd_reg, MASK);
        chk({tag, "_dat_in"}, vme_dat_reg_in, 0);
        chk({tag, "_rd_valid"}, rd_valid, 0);
        chk({tag, "_rd_data"}, rd_data, 0);
        chk({tag, "_rd_instr"}, rd_instr, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err_cnt"}, err_cnt, 0);
        chk({tag, "_timeout_err"}, timeout_err, 0);
        chk({tag, "_load_full"}, load_full, 0);
    endtask

    // Watchdog: the whole run stays far below this.
    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, got running, expected finished");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        bit [31:0] r;
        bit        rw;
        bit [15:0] d;
        rst = 1; clr = 0; load_en = 0; load_rw = 0; load_instr = 0; load_data = 0;
        load_chk = 0; run = 0; m_busy = 0; rdy_rand = 0; tx_idx = 0;
        vme_cmd_rd = 0; vme_dat_wr = 0; vme_dat_reg_out = 0;
        for (int i = 0; i < DEPTH; i++) begin ack_dly[i] = 0; rb_val[i] = 0; end
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst = 0;
        @(negedge clk);

        // Directed write + checked read, matching readback.
        load(0, 16'h4100, 16'h1234, 0);
        load(1, 16'h4200, 16'h00AB, 1);
        ack_dly[0] = 2; ack_dly[1] = 2;
        rb_val[0] = 32'hDEAD_0000; rb_val[1] = 32'h0000_00AB;
        do_run(0, 0);
        chk("t1_err_cnt", err_cnt, 0);

        // Same list, mismatching readback; then replay again.
        rb_val[1] = 32'hFFFF_00AC;
        do_run(0, 0);
        chk("t2_err_cnt", err_cnt, 1);
        do_run(0, 0);
        chk("t2_rerun_err_cnt", err_cnt, 1);

        // Overfill: DEPTH+1 loads, the extra one dropped.
        do_clr();
        for (int i = 0; i <= DEPTH; i++) begin
            load(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
            ack_dly[i % DEPTH] = $urandom_range(0, 3);
            rb_val[i % DEPTH]  = $urandom;
        end
        chk("overfill_list_size", ref_list.size(), DEPTH);
        rdy_rand = 1;
        do_run(1, 0);

        // Acknowledge on the last allowed timer cycle still completes.
        do_clr();
        load(1, 16'h0042, 16'h0F0F, 1);
        ack_dly[0] = TIMEOUT; rb_val[0] = 32'h0000_0F0F;
        do_run(0, 0);
        chk("ack_at_limit_no_timeout", timeout_err, 0);

        // Timeout on the second entry aborts the rest.
        do_clr();
        load(0, 16'h1000, 16'h0001, 0);
        load(0, 16'h1001, 16'h0002, 0);
        load(1, 16'h1002, 16'h0003, 1);
        ack_dly[0] = 1; ack_dly[1] = NOACK; ack_dly[2] = 0;
        do_run(0, 0);
        chk("timeout_err_sticky", timeout_err, 1);
        chk("cmd_idle_after_abort", vme_cmd_reg, MASK);

        // Empty buffer run.
        do_clr();
        do_run(0, 0);

        // run with a simultaneous load: load dropped.
        load(0, 16'h2222, 16'h3333, 0);
        ack_dly[0] = 0; ack_dly[1] = 0;
        do_run(0, 1);
        chk("run_load_same_size", ref_list.size(), 1);
        do_run(0, 0);

        // Randomised lists and decoder timing.
        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 2) == 0) do_clr();
            for (int k = $urandom_range(0, 3); k > 0; k--) begin
                rw = 1'($urandom_range(0, 1));
                d  = 16'($urandom);
                load(rw, 16'($urandom), d, 1'($urandom_range(0, 1)));
            end
            for (int i = 0; i < DEPTH; i++) begin
                r = $urandom;
                rb_val[i]  = (i < ref_list.size() && $urandom_range(0, 1) == 1) ?
                             {r[31:16], ref_list[i].data} : r;
                ack_dly[i] = ($urandom_range(0, 9) == 0) ? NOACK : $urandom_range(0, TIMEOUT);
            end
            rdy_rand = 1'($urandom_range(0, 1));
            do_run(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset in the middle of a replay.
        do_clr();
        rdy_rand = 0;
        load(1, 16'h3000, 16'h0001, 1);
        load(0, 16'h3001, 16'h0002, 0);
        load(0, 16'h3002, 16'h0003, 0);
        ack_dly[0] = 0; ack_dly[1] = 6; ack_dly[2] = 6;
        rb_val[0] = 32'h0000_0002;
        predict();
        tx_idx = 0;
        run = 1;
        @(negedge clk);
        run = 0;
        m_busy = 1;
        repeat (4) @(negedge clk);
        chk("pre_reset_err_cnt", err_cnt, 1);
        chk("pre_reset_busy", busy, 1);
        #2 rst = 1;
        #1 check_reset_vals("midrst");
        exp_cmd.delete(); exp_rd.delete(); exp_done.delete();
        ref_list.delete();
        @(negedge clk);
        rst = 0;
        mon_starts = 0;
        m_busy = 0;
        @(negedge clk);
        do_run(0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
